useq_sequencer: RTL and testbench

- Microprogram sequencer and pipeline register that sit directly upstream of the Am2901 slice controller.
- Each cycle it supplies the control-store address, captures the returned microword, and drives the slice fields i[8:0], a[3:0] and b[3:0] from that pipeline register.
- It provides a subroutine stack, a loop counter and conditional branching on a slice status bit (z, ovr, c or similar, selected externally).

---
 rtl/useq_pkg.sv | 36 +++
 rtl/useq_stack.sv | 59 +++++
 rtl/useq_sequencer.sv | 129 ++++++++++++
 tb/tb_useq_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencer op encodings,
// the slice NOP opcode, microword field widths and the pipeline-word layout.
package useq_pkg;

  localparam int I_W   = 9;
  localparam int A_W   = 4;
  localparam int B_W   = 4;
  localparam int SEQ_W = 3;

  // Slice opcode that writes no register, leaves Q alone and passes F to Y.
  localparam logic [I_W-1:0] NOP_I = 9'h044;

  typedef enum logic [SEQ_W-1:0] {
    SEQ_CONT = 3'd0,
    SEQ_JMP  = 3'd1,
    SEQ_CJMP = 3'd2,
    SEQ_CJSR = 3'd3,
    SEQ_CRET = 3'd4,
    SEQ_LDCT = 3'd5,
    SEQ_RPCT = 3'd6,
    SEQ_JMAP = 3'd7
  } seq_op_e;

  // Fixed-width part of the pipeline word. The branch/count literal is
  // ADDR_W wide and so is held alongside this struct in the top level.
  typedef struct packed {
    logic [I_W-1:0] i;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    seq_op_e        seq;
    logic           pol;
  } pipe_ctl_t;

  localparam pipe_ctl_t NOP_CTL = '{i: NOP_I, a: '0, b: '0, seq: SEQ_CONT, pol: 1'b0};

endpackage

// File: rtl/useq_stack.sv
// Subroutine return-address LIFO. Push while full and pop while empty are
// ignored and reported as single-cycle ovf/unf pulses for the caller.
module useq_stack
  import useq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_SP = (PW+1)'(DEPTH);

  logic [PW:0]               sp_q, sp_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic [PW-1:0]             top_idx;

  // Wraps correctly when sp==DEPTH: low bits are 0, minus one is DEPTH-1.
  assign top_idx = sp_q[PW-1:0] - 1'b1;
  assign top     = mem_q[top_idx];
  assign full    = (sp_q == FULL_SP);
  assign empty   = (sp_q == '0);

  // Next stack pointer and contents; illegal operations leave state alone.
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    ovf   = push & full;
    unf   = pop & empty;
    if (push && !full) begin
      mem_d[sp_q[PW-1:0]] = din;
      sp_d                = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  // Stack state register; reset discards all entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      mem_q <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/useq_sequencer.sv
// Microprogram sequencer and pipeline register feeding the Am2901 slice
// controller. Optional macro USEQ_MAP_EN adds the map_addr port and makes
// op JMAP jump to it; without the macro JMAP behaves as CONT.
module useq_sequencer
  import useq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              cond,
  input  logic [I_W-1:0]    rom_i,
  input  logic [A_W-1:0]    rom_a,
  input  logic [B_W-1:0]    rom_b,
  input  logic [SEQ_W-1:0]  rom_seq,
  input  logic              rom_pol,
  input  logic [ADDR_W-1:0] rom_br,
`ifdef USEQ_MAP_EN
  input  logic [ADDR_W-1:0] map_addr,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [I_W-1:0]    i,
  output logic [A_W-1:0]    a,
  output logic [B_W-1:0]    b,
  output logic              stk_full,
  output logic              stk_err
);

  pipe_ctl_t           pipe_q, pipe_d;
  logic [ADDR_W-1:0]   br_q, br_d;
  logic [ADDR_W-1:0]   upc_q, upc_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                pass, push, pop;
  logic [ADDR_W-1:0]   stk_top;
  logic                stk_empty, stk_ovf, stk_unf;

  useq_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (upc_q),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .ovf   (stk_ovf),
    .unf   (stk_unf)
  );

  // Next-address mux and op side effects, decided by the word in pipe.
  always_comb begin
    pass  = cond ^ pipe_q.pol;
    addr  = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    cnt_d = cnt_q;
    case (pipe_q.seq)
      SEQ_JMP:  addr = br_q;
      SEQ_CJMP: if (pass) addr = br_q;
      SEQ_CJSR: if (pass) begin
                  addr = br_q;
                  push = 1'b1;
                end
      SEQ_CRET: if (pass) begin
                  pop = 1'b1;
                  if (!stk_empty) addr = stk_top;
                end
      SEQ_LDCT: cnt_d = br_q;
      SEQ_RPCT: if (cnt_q != '0) begin
                  addr  = br_q;
                  cnt_d = cnt_q - 1'b1;
                end
`ifdef USEQ_MAP_EN
      SEQ_JMAP: addr = map_addr;
`endif
      default:  ;
    endcase
    // A stall still presents the address but must not disturb any state.
    if (hold) begin
      push  = 1'b0;
      pop   = 1'b0;
      cnt_d = cnt_q;
    end
  end

  // Pipeline capture, uPC increment and sticky stack error.
  always_comb begin
    pipe_d = pipe_q;
    br_d   = br_q;
    upc_d  = upc_q;
    err_d  = err_q;
    if (!hold) begin
      pipe_d = '{i: rom_i, a: rom_a, b: rom_b, seq: seq_op_e'(rom_seq), pol: rom_pol};
      br_d   = rom_br;
      upc_d  = addr + 1'b1;
      err_d  = err_q | stk_ovf | stk_unf;
    end
  end

  // Slice fields follow pipe, forced to NOP while stalled.
  always_comb begin
    i = hold ? NOP_I : pipe_q.i;
    a = hold ? '0    : pipe_q.a;
    b = hold ? '0    : pipe_q.b;
  end

  assign stk_err = err_q;

  // Sequencer state registers with synchronous reset to a NOP/CONT word.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= NOP_CTL;
      br_q   <= '0;
      upc_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      br_q   <= br_d;
      upc_q  <= upc_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Bench for useq_sequencer: directed microprogram with literal address trace,
// then randomized ROM/cond/hold/reset against a queue-based reference model.
module tb_useq_sequencer;

  localparam int AW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hold = 1'b0;
  logic          cond = 1'b0;
  logic [8:0]    rom_i;
  logic [3:0]    rom_a, rom_b;
  logic [2:0]    rom_seq;
  logic          rom_pol;
  logic [AW-1:0] rom_br;
  logic [AW-1:0] addr;
  logic [8:0]    i;
  logic [3:0]    a, b;
  logic          stk_full, stk_err;
`ifdef USEQ_MAP_EN
  logic [AW-1:0] map_addr = 8'h7F;
`endif

  // Combinational control store
  logic [8:0] r_i   [256];
  logic [3:0] r_a   [256];
  logic [3:0] r_b   [256];
  logic [2:0] r_seq [256];
  logic       r_pol [256];
  logic [7:0] r_br  [256];

  assign rom_i   = r_i[addr];
  assign rom_a   = r_a[addr];
  assign rom_b   = r_b[addr];
  assign rom_seq = r_seq[addr];
  assign rom_pol = r_pol[addr];
  assign rom_br  = r_br[addr];

  useq_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .cond     (cond),
    .rom_i    (rom_i),
    .rom_a    (rom_a),
    .rom_b    (rom_b),
    .rom_seq  (rom_seq),
    .rom_pol  (rom_pol),
    .rom_br   (rom_br),
`ifdef USEQ_MAP_EN
    .map_addr (map_addr),
`endif
    .addr     (addr),
    .i        (i),
    .a        (a),
    .b        (b),
    .stk_full (stk_full),
    .stk_err  (stk_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_map = 1'b0;

  // Reference model state
  logic [7:0] m_upc, m_cnt, m_br;
  logic [8:0] m_i;
  logic [3:0] m_a, m_b;
  logic [2:0] m_seq;
  logic       m_pol;
  logic       m_err;
  logic [7:0] m_stk[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_upc = 8'h00; m_cnt = 8'h00; m_br = 8'h00;
    m_i = 9'h044; m_a = 4'h0; m_b = 4'h0; m_seq = 3'd0; m_pol = 1'b0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  function automatic logic [7:0] m_next();
    logic p;
    p = cond ^ m_pol;
    case (m_seq)
      3'd1:       return m_br;
      3'd2, 3'd3: return p ? m_br : m_upc;
      3'd4:       return (p && m_stk.size() > 0) ? m_stk[$] : m_upc;
      3'd6:       return (m_cnt != 8'h00) ? m_br : m_upc;
`ifdef USEQ_MAP_EN
      3'd7:       return map_addr;
`endif
      default:    return m_upc;
    endcase
  endfunction

  task automatic m_clock(input logic [7:0] ea);
    logic p;
    p = cond ^ m_pol;
    if (reset) m_reset();
    else if (!hold) begin
      case (m_seq)
        3'd3: if (p) begin
                if (m_stk.size() < SD) m_stk.push_back(m_upc);
                else m_err = 1'b1;
              end
        3'd4: if (p) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_err = 1'b1;
              end
        3'd5: m_cnt = m_br;
        3'd6: if (m_cnt != 8'h00) m_cnt = m_cnt - 8'h01;
        default: ;
      endcase
      m_i = r_i[ea]; m_a = r_a[ea]; m_b = r_b[ea];
      m_seq = r_seq[ea]; m_pol = r_pol[ea]; m_br = r_br[ea];
      m_upc = ea + 8'h01;
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare, advance model.
  task automatic step(input logic c, input logic h, input logic r);
    logic [7:0] ea;
    @(negedge clk);
    cond = c; hold = h; reset = r;
`ifdef USEQ_MAP_EN
    if (rnd_map) map_addr = 8'($urandom);
`endif
    #1;
    ea = m_next();
    chk("addr",     32'(addr),     32'(ea));
    chk("i",        32'(i),        32'(h ? 9'h044 : m_i));
    chk("a",        32'(a),        32'(h ? 4'h0 : m_a));
    chk("b",        32'(b),        32'(h ? 4'h0 : m_b));
    chk("stk_full", 32'(stk_full), 32'(m_stk.size() == SD));
    chk("stk_err",  32'(stk_err),  32'(m_err));
    m_clock(ea);
  endtask

  task automatic rom_word(input int ad, input logic [2:0] sq, input logic pl, input logic [7:0] br);
    r_seq[ad] = sq; r_pol[ad] = pl; r_br[ad] = br;
  endtask

  localparam int NDIR = 34;
  logic [7:0] exp_addr [NDIR] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h20, 8'h21, 8'h22, 8'h40,
    8'h41, 8'h50, 8'h10, 8'h11, 8'h12, 8'h11, 8'h11, 8'h11, 8'h11, 8'h12,
    8'h11, 8'h12, 8'h13, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'h81, 8'h71,
    8'h61, 8'h14, 8'h15, 8'h16};

  initial begin
    // Directed control store
    for (int k = 0; k < 256; k++) begin
      r_i[k] = {1'b1, 8'(k)}; r_a[k] = 4'(k); r_b[k] = ~4'(k);
      rom_word(k, 3'd0, 1'b0, 8'h00);
    end
    rom_word(8'h05, 3'd1, 1'b0, 8'h20);
    rom_word(8'h21, 3'd2, 1'b0, 8'h40);
    rom_word(8'h22, 3'd2, 1'b0, 8'h40);
    rom_word(8'h40, 3'd2, 1'b1, 8'h50);
    rom_word(8'h41, 3'd2, 1'b1, 8'h50);
    rom_word(8'h50, 3'd1, 1'b0, 8'h10);
    rom_word(8'h10, 3'd5, 1'b0, 8'h02);
    rom_word(8'h12, 3'd6, 1'b0, 8'h11);
    r_i[8'h12] = 9'h1AB;
    rom_word(8'h13, 3'd3, 1'b0, 8'h60);
    rom_word(8'h60, 3'd3, 1'b0, 8'h70);
    rom_word(8'h70, 3'd3, 1'b0, 8'h80);
    rom_word(8'h80, 3'd3, 1'b0, 8'h90);
    rom_word(8'h90, 3'd3, 1'b0, 8'hA0);
    rom_word(8'hA0, 3'd4, 1'b0, 8'h00);
    rom_word(8'h81, 3'd4, 1'b0, 8'h00);
    rom_word(8'h71, 3'd4, 1'b0, 8'h00);
    rom_word(8'h61, 3'd4, 1'b0, 8'h00);
    rom_word(8'h14, 3'd4, 1'b0, 8'h00);
`ifdef USEQ_MAP_EN
    rom_word(8'h16, 3'd7, 1'b0, 8'h00);
`endif
    m_reset();  // DUT is reset at the first rising edge

    for (int k = 0; k < NDIR; k++) begin
      logic c, h;
      c = (k == 9 || k == 10 || (k >= 23 && k <= 32));
      h = (k >= 15 && k <= 17);
      step(c, h, 1'b0);
      chk("dir_addr", 32'(addr), 32'(exp_addr[k]));
      if (k == 0)  chk("reset_i_nop", 32'(i), 32'h044);
      if (h)       chk("hold_i_nop", 32'(i), 32'h044);
      if (k == 26) chk("err_before_ovf", 32'(stk_err), 32'h0);
      if (k == 27) chk("stk_full_4", 32'(stk_full), 32'h1);
      if (k == 28) chk("err_after_ovf", 32'(stk_err), 32'h1);
    end
`ifdef USEQ_MAP_EN
    step(1'b0, 1'b0, 1'b0);
    chk("jmap_addr", 32'(addr), 32'h7F);
`endif

    // Random phase: reset, reload a random control store, then free-run
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 256; k++) begin
      r_i[k] = 9'($urandom); r_a[k] = 4'($urandom); r_b[k] = 4'($urandom);
      rom_word(k, 3'($urandom), 1'($urandom), 8'($urandom));
    end
    rnd_map = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
